seq_addsub: RTL and testbench
=============================

Name: seq_addsub

Overview:
- Parametrised multi-cycle adder/subtractor built from a DIGIT-bit full-adder slice plus a registered carry.
- Processes one DIGIT-bit digit of the operands per clock, LSB first.
- Offers a start/busy/done handshake so datapath blocks can share one narrow adder slice instead of a full-width combinational ripple adder.
- Outputs sum, carry-out and signed overflow, held stable until the next operation completes.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly; N = WIDTH/DIGIT cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled on clk edge.
- sub  input  1  0 = a+b, 1 = a−b (two's complement); captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result outputs valid and newly updated.
- s  output  WIDTH  result (a+b or a−b, modulo 2^WIDTH).
- cout  output  1  carry out of MSB (for sub: 1 = no borrow, i.e. a ≥ b unsigned).
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- One clock domain. Reset is synchronous and active-high on reset.
- Reset drives state=IDLE, busy=0, done=0, s=0, cout=0, ovf=0, and clears all internal registers.
- States: IDLE, RUN.
- IDLE with start=1 at edge E0:
  - latch opA=a, opB = sub ? ~b : b, carry=sub, digit count=0;
  - busy=1 from E0; state → RUN.
- RUN, edges E1..EN: each edge computes digit i = count:
  - {c_next, sum_i} = opA[i] + opB[i] + carry, a DIGIT-bit full-adder chain;
  - store sum_i into an internal result shift register, carry ← c_next, count++.
- At edge EN (last digit):
  - s ← assembled result, cout ← final carry, ovf ← (carry into bit WIDTH−1) XOR (carry out of bit WIDTH−1);
  - done=1, busy=0, state → IDLE.
- done is high for exactly one cycle, between EN and EN+1.
- Latency: start sampled at E0 → done high after EN, with N = WIDTH/DIGIT. Throughput: one operation per N cycles.
- s/cout/ovf change only at completion. During RUN they hold the previous result.
- start while busy=1 is ignored; no queueing, and captured operands are unaffected.
- start in the cycle done=1: accepted, because state is already IDLE. done then falls and busy rises at the same edge.
- a, b and sub may change freely after E0 without affecting the operation.
- reset during RUN aborts the operation: no done pulse, outputs cleared to 0, and the next start behaves as from power-up.
- reset and start at the same edge: reset wins and start is dropped.
- Overflow carry-into-MSB is captured internally during the digit containing bit WIDTH−1. For DIGIT > 1 it comes from the slice-internal chain.

Test Plan:
- WIDTH=8, DIGIT=1:
  - start, a=0x0F, b=0x01, sub=0 → busy for 8 cycles, done pulse 8 edges after start, s=0x10, cout=0, ovf=0.
  - a=0xFF, b=0x01, sub=0 → s=0x00, cout=1, ovf=0.
  - a=0x7F, b=0x01, sub=0 → s=0x80, cout=0, ovf=1.
  - sub=1, a=0x05, b=0x07 → s=0xFE, cout=0, ovf=0.
  - sub=1, a=0x80, b=0x01 → s=0x7F, cout=1, ovf=1.
- Handshake (WIDTH=8, DIGIT=1):
  - start 0x10+0x20, then pulse start with a=0xFF, b=0xFF at edge E3 → ignored; done at E8 with s=0x30; s held at 0x30 through the following idle cycles.
  - start asserted in the done cycle → back-to-back operation accepted; second done exactly 8 edges later.
- Reset: start 0x55+0xAA, assert reset at E4 → busy=0, s=0, no done pulse. A subsequent start 0x01+0x01 gives s=0x02 after 8 edges.
- Parameter sweep: WIDTH=8, DIGIT=4 → done 2 edges after start; WIDTH=4, DIGIT=1 and DIGIT=2, exhaustive over all a, b, sub (512 ops each) → s, cout, ovf match the reference model a ± b.

Source files
------------

// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: one DIGIT-bit full-adder slice and a registered
// carry process the operands LSB-first, one digit per clock.

module seq_addsub_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module seq_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] op_a, op_b, res, res_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] sum_d;
    logic             last, accept, step;

    // Operands shift right each step, so the slice always sees the low digit.
    assign c[0] = carry;
    for (genvar j = 0; j < DIGIT; j++) begin : g_fa
        seq_addsub_fa u_fa (
            .a  (op_a[j]),
            .b  (op_b[j]),
            .ci (c[j]),
            .s  (sum_d[j]),
            .co (c[j+1])
        );
    end

    assign last    = (cnt == CW'(N - 1));
    assign res_nxt = (res >> DIGIT) | (WIDTH'(sum_d) << (WIDTH - DIGIT));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == RUN);
        accept = (state == IDLE) && start;
        step   = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                op_a  <= a;
                op_b  <= sub ? ~b : b;
                carry <= sub;
                cnt   <= '0;
                res   <= '0;
            end else if (step) begin
                op_a  <= op_a >> DIGIT;
                op_b  <= op_b >> DIGIT;
                carry <= c[DIGIT];
                cnt   <= cnt + CW'(1);
                res   <= res_nxt;
                // Last digit holds the MSB: c[DIGIT-1] is the carry into it.
                if (last) begin
                    s    <= res_nxt;
                    cout <= c[DIGIT];
                    ovf  <= c[DIGIT] ^ c[DIGIT-1];
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_addsub.sv
// Directed bench for seq_addsub: 8-bit (DIGIT 1 and 4) vectors, handshake and
// reset cases, plus exhaustive 4-bit sweeps for DIGIT 1 and 2.
module tb_seq_addsub;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start8, sub8;
    logic [7:0] a8, b8;
    logic       start4, sub4;
    logic [3:0] a4, b4;

    logic       busy81, done81, cout81, ovf81;
    logic [7:0] s81;
    logic       busy84, done84, cout84, ovf84;
    logic [7:0] s84;
    logic       busy41, done41, cout41, ovf41;
    logic [3:0] s41;
    logic       busy42, done42, cout42, ovf42;
    logic [3:0] s42;

    int errors = 0;
    int checks = 0;

    seq_addsub #(.WIDTH(8), .DIGIT(1)) dut81 (
        .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy81), .done(done81), .s(s81), .cout(cout81), .ovf(ovf81));
    seq_addsub #(.WIDTH(8), .DIGIT(4)) dut84 (
        .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy84), .done(done84), .s(s84), .cout(cout84), .ovf(ovf84));
    seq_addsub #(.WIDTH(4), .DIGIT(1)) dut41 (
        .clk(clk), .reset(reset), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy41), .done(done41), .s(s41), .cout(cout41), .ovf(ovf41));
    seq_addsub #(.WIDTH(4), .DIGIT(2)) dut42 (
        .clk(clk), .reset(reset), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy42), .done(done42), .s(s42), .cout(cout42), .ovf(ovf42));

    task automatic test_reset();
        reset = 1'b1; start8 = 1'b0; start4 = 1'b0;
        sub8 = 1'b0; a8 = '0; b8 = '0; sub4 = 1'b0; a4 = '0; b4 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy81, done81, s81, cout81, ovf81} !== 11'd0) begin
            errors++; $display("FAIL reset81: got %h expected 0", {busy81, done81, s81, cout81, ovf81});
        end
        checks++;
        if ({busy42, done42, s42, cout42, ovf42} !== 8'd0) begin
            errors++; $display("FAIL reset42: got %h expected 0", {busy42, done42, s42, cout42, ovf42});
        end
        reset = 1'b0;
    endtask

    // Runs one op on both 8-bit DUTs; DIGIT=1 finishes after 8 edges, DIGIT=4 after 2.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sb,
                        input logic [7:0] es, input logic ec, input logic eo);
        @(negedge clk); start8 = 1'b1; a8 = a; b8 = b; sub8 = sb;
        @(negedge clk); start8 = 1'b0; a8 = ~a; b8 = ~b; sub8 = ~sb;
        checks++;
        if (busy81 !== 1'b1) begin errors++; $display("FAIL busy81_start: got %b expected 1", busy81); end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (done81 !== (k == 8)) begin
                errors++; $display("FAIL done81_timing k=%0d: got %b expected %b", k, done81, (k == 8));
            end
            checks++;
            if (done84 !== (k == 2)) begin
                errors++; $display("FAIL done84_timing k=%0d: got %b expected %b", k, done84, (k == 2));
            end
            if (k < 8) begin
                checks++;
                if (busy81 !== 1'b1) begin errors++; $display("FAIL busy81_run k=%0d: got %b expected 1", k, busy81); end
            end
            if (k == 2) begin
                checks++;
                if ({s84, cout84, ovf84} !== {es, ec, eo}) begin
                    errors++; $display("FAIL result84 %h%s%h: got s=%h c=%b o=%b expected s=%h c=%b o=%b",
                                       a, sb ? "-" : "+", b, s84, cout84, ovf84, es, ec, eo);
                end
            end
            if (k == 8) begin
                checks++;
                if ({busy81, s81, cout81, ovf81} !== {1'b0, es, ec, eo}) begin
                    errors++; $display("FAIL result81 %h%s%h: got busy=%b s=%h c=%b o=%b expected busy=0 s=%h c=%b o=%b",
                                       a, sb ? "-" : "+", b, busy81, s81, cout81, ovf81, es, ec, eo);
                end
            end
        end
    endtask

    task automatic test_add_sub();
        run8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        run8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    endtask

    task automatic test_ignore_start();
        @(negedge clk); start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0;
        @(negedge clk); start8 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 2) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; end
            if (k == 3) start8 = 1'b0;
            checks++;
            if (done81 !== (k == 8)) begin
                errors++; $display("FAIL ignore_done k=%0d: got %b expected %b", k, done81, (k == 8));
            end
        end
        checks++;
        if ({s81, cout81, ovf81} !== {8'h30, 1'b0, 1'b0}) begin
            errors++; $display("FAIL ignore_result: got s=%h c=%b o=%b expected s=30 c=0 o=0", s81, cout81, ovf81);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({done81, busy81, s81} !== {1'b0, 1'b0, 8'h30}) begin
                errors++; $display("FAIL hold_idle: got done=%b busy=%b s=%h expected 0 0 30", done81, busy81, s81);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; sub8 = 1'b0;
        @(negedge clk); start8 = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if ({done81, s81} !== {1'b1, 8'h03}) begin
            errors++; $display("FAIL b2b_first: got done=%b s=%h expected 1 03", done81, s81);
        end
        start8 = 1'b1; a8 = 8'h03; b8 = 8'h04;
        @(negedge clk); start8 = 1'b0;
        checks++;
        if ({done81, busy81} !== 2'b01) begin
            errors++; $display("FAIL b2b_accept: got done=%b busy=%b expected 0 1", done81, busy81);
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (done81 !== (k == 8)) begin
                errors++; $display("FAIL b2b_done k=%0d: got %b expected %b", k, done81, (k == 8));
            end
            if (k == 4) begin
                checks++;
                if (s81 !== 8'h03) begin errors++; $display("FAIL b2b_hold: got %h expected 03", s81); end
            end
        end
        checks++;
        if (s81 !== 8'h07) begin errors++; $display("FAIL b2b_second: got %h expected 07", s81); end
    endtask

    task automatic test_reset_abort();
        int seen;
        @(negedge clk); start8 = 1'b1; a8 = 8'h55; b8 = 8'hAA; sub8 = 1'b0;
        @(negedge clk); start8 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        checks++;
        if ({busy81, done81, s81, cout81, ovf81} !== 11'd0) begin
            errors++; $display("FAIL abort_clear: got %h expected 0", {busy81, done81, s81, cout81, ovf81});
        end
        seen = 0;
        repeat (10) begin @(negedge clk); if (done81 === 1'b1) seen++; end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen); end
        run8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
    endtask

    task automatic test_reset_start();
        int seen;
        @(negedge clk); reset = 1'b1; start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
        @(negedge clk); reset = 1'b0; start8 = 1'b0;
        checks++;
        if (busy81 !== 1'b0) begin errors++; $display("FAIL reset_wins_busy: got %b expected 0", busy81); end
        seen = 0;
        repeat (10) begin @(negedge clk); if (done81 === 1'b1 || done84 === 1'b1) seen++; end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL reset_wins_done: got %0d pulses expected 0", seen); end
    endtask

    task automatic test_exhaustive4();
        logic [3:0] av, bv, bb;
        logic [4:0] full;
        logic       sb, eo;
        for (int si = 0; si < 2; si++)
            for (int ai = 0; ai < 16; ai++)
                for (int bi = 0; bi < 16; bi++) begin
                    av = ai[3:0]; bv = bi[3:0]; sb = si[0];
                    bb = sb ? ~bv : bv;
                    full = {1'b0, av} + {1'b0, bb} + {4'b0, sb};
                    eo = sb ? ((av[3] != bv[3]) && (full[3] != av[3]))
                            : ((av[3] == bv[3]) && (full[3] != av[3]));
                    @(negedge clk); start4 = 1'b1; a4 = av; b4 = bv; sub4 = sb;
                    @(negedge clk); start4 = 1'b0;
                    for (int k = 1; k <= 4; k++) begin
                        @(negedge clk);
                        if (k == 2) begin
                            checks++;
                            if ({done42, s42, cout42, ovf42} !== {1'b1, full[3:0], full[4], eo}) begin
                                errors++; $display("FAIL w4d2 %h%s%h: got done=%b s=%h c=%b o=%b expected 1 %h %b %b",
                                                   av, sb ? "-" : "+", bv, done42, s42, cout42, ovf42, full[3:0], full[4], eo);
                            end
                        end
                        if (k == 4) begin
                            checks++;
                            if ({done41, s41, cout41, ovf41} !== {1'b1, full[3:0], full[4], eo}) begin
                                errors++; $display("FAIL w4d1 %h%s%h: got done=%b s=%h c=%b o=%b expected 1 %h %b %b",
                                                   av, sb ? "-" : "+", bv, done41, s41, cout41, ovf41, full[3:0], full[4], eo);
                            end
                        end
                    end
                end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_reset_start();
        test_exhaustive4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
